clock_display_mux: RTL and testbench

//  Downstream display stage for the hh:mm:ss counter chain. Consumes count_sec/count_min/count_hrs,

---
 rtl/clock_display_mux_pkg.sv | 45 ++++
 rtl/clock_display_mux_bin2bcd.sv | 23 ++
 rtl/clock_display_mux.sv | 110 +++++++++++
 tb/tb_clock_display_mux.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_display_mux_pkg.sv
// rtl/clock_display_mux_pkg.sv - shared constants and segment decode for the clock display mux
package clock_display_mux_pkg;

    localparam int NUM_DIGITS = 6;

    // Segment patterns are {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    localparam logic [2:0] IDX_SEC_UNITS = 3'd0;
    localparam logic [2:0] IDX_SEC_TENS  = 3'd1;
    localparam logic [2:0] IDX_MIN_UNITS = 3'd2;
    localparam logic [2:0] IDX_MIN_TENS  = 3'd3;
    localparam logic [2:0] IDX_HRS_UNITS = 3'd4;
    localparam logic [2:0] IDX_HRS_TENS  = 3'd5;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/clock_display_mux_bin2bcd.sv
// rtl/clock_display_mux_bin2bcd.sv - combinational 0..99 binary to two BCD digits with overflow flag
module bin2bcd_99 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [3:0]       tens_o,
    output logic [3:0]       units_o,
    output logic             ovf_o
);

    logic [6:0] low7;
    logic [3:0] tens4;

    // Only the low 7 bits matter once the full-width compare has ruled out >= 100
    always_comb begin
        ovf_o   = (bin_i > WIDTH'(99));
        low7    = bin_i[6:0];
        tens4   = 4'(low7 / 7'd10);
        tens_o  = ovf_o ? 4'd0 : tens4;
        units_o = ovf_o ? 4'd0 : 4'(low7 - 7'(tens4) * 7'd10);
    end

endmodule

// File: rtl/clock_display_mux.sv
// rtl/clock_display_mux.sv - snapshots hh:mm:ss and scans it onto a 6-digit multiplexed 7-segment display
module clock_display_mux
    import clock_display_mux_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int REFRESH_DIV = 100000,
    parameter int SEG_ACT_LOW = 1,
    parameter int AN_ACT_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      count_sec,
    input  logic [WIDTH-1:0]      count_min,
    input  logic [WIDTH-1:0]      count_hrs,
    input  logic                  blank,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int               CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic             SEG_INV  = (SEG_ACT_LOW != 0);
    localparam logic             AN_INV   = (AN_ACT_LOW != 0);

    logic [CNT_W-1:0]      refresh_cnt_q, refresh_cnt_d;
    logic [2:0]            digit_idx_q, digit_idx_d;
    logic [WIDTH-1:0]      sec_q, min_q, hrs_q;
    logic                  load_pending_q;
    logic                  digit_step;
    logic                  snap_load;
    logic [WIDTH-1:0]      field;
    logic [3:0]            bcd_tens, bcd_units;
    logic                  bcd_ovf;
    logic [NUM_DIGITS-1:0] an_d;
    logic [6:0]            seg_d;
    logic                  dp_d;

    always_comb begin
        digit_step    = (refresh_cnt_q == CNT_LAST);
        refresh_cnt_d = digit_step ? '0 : refresh_cnt_q + 1'b1;
        digit_idx_d   = digit_idx_q;
        if (digit_step) begin
            digit_idx_d = (digit_idx_q == IDX_HRS_TENS) ? IDX_SEC_UNITS : digit_idx_q + 3'd1;
        end
        // A frame's values are latched only at its start so a digit pair never mixes two inputs
        snap_load = load_pending_q | (digit_step & (digit_idx_q == IDX_HRS_TENS));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_cnt_q  <= '0;
            digit_idx_q    <= IDX_SEC_UNITS;
            load_pending_q <= 1'b1;
            sec_q          <= '0;
            min_q          <= '0;
            hrs_q          <= '0;
        end else begin
            refresh_cnt_q  <= refresh_cnt_d;
            digit_idx_q    <= digit_idx_d;
            load_pending_q <= 1'b0;
            if (snap_load) begin
                sec_q <= count_sec;
                min_q <= count_min;
                hrs_q <= count_hrs;
            end
        end
    end

    always_comb begin
        case (digit_idx_q)
            IDX_SEC_UNITS, IDX_SEC_TENS: field = sec_q;
            IDX_MIN_UNITS, IDX_MIN_TENS: field = min_q;
            default:                     field = hrs_q;
        endcase
    end

    bin2bcd_99 #(
        .WIDTH(WIDTH)
    ) u_bin2bcd (
        .bin_i  (field),
        .tens_o (bcd_tens),
        .units_o(bcd_units),
        .ovf_o  (bcd_ovf)
    );

    always_comb begin
        an_d  = '0;
        seg_d = SEG_OFF;
        dp_d  = 1'b0;
        if (!blank) begin
            an_d  = NUM_DIGITS'(1) << digit_idx_q;
            seg_d = bcd_ovf ? SEG_DASH : seg_decode(digit_idx_q[0] ? bcd_tens : bcd_units);
            dp_d  = ((digit_idx_q == IDX_MIN_UNITS) || (digit_idx_q == IDX_HRS_UNITS)) && !sec_q[0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= {NUM_DIGITS{AN_INV}};
            seg <= {7{SEG_INV}};
            dp  <= SEG_INV;
        end else begin
            an  <= an_d ^ {NUM_DIGITS{AN_INV}};
            seg <= seg_d ^ {7{SEG_INV}};
            dp  <= dp_d ^ SEG_INV;
        end
    end

endmodule

// File: tb/tb_clock_display_mux.sv
// tb/tb_clock_display_mux.sv - self-checking bench for clock_display_mux (REFRESH_DIV 4 and 1)
module tb_clock_display_mux;

    localparam logic [13:0] INACT = {6'b111111, 7'b1111111, 1'b1};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        blank = 1'b0;
    logic [31:0] sec = 32'd7;
    logic [31:0] min = 32'd34;
    logic [31:0] hrs = 32'd12;
    logic [6:0]  seg4, seg1;
    logic        dp4, dp1;
    logic [5:0]  an4, an1;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;

    always #5 clk = ~clk;

    clock_display_mux #(.WIDTH(32), .REFRESH_DIV(4), .SEG_ACT_LOW(1), .AN_ACT_LOW(1)) dut4 (
        .clk(clk), .reset(reset), .count_sec(sec), .count_min(min), .count_hrs(hrs),
        .blank(blank), .seg(seg4), .dp(dp4), .an(an4)
    );

    clock_display_mux #(.WIDTH(32), .REFRESH_DIV(1), .SEG_ACT_LOW(1), .AN_ACT_LOW(1)) dut1 (
        .clk(clk), .reset(reset), .count_sec(sec), .count_min(min), .count_hrs(hrs),
        .blank(blank), .seg(seg1), .dp(dp1), .an(an1)
    );

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            default: return 7'b1101111;
        endcase
    endfunction

    // Expected {an,seg,dp} (active-low) for a given digit position and frame values
    function automatic logic [13:0] model_out(input int idx, input logic [31:0] s,
                                              input logic [31:0] m, input logic [31:0] h,
                                              input logic blk);
        logic [31:0] f;
        logic [6:0]  p;
        logic [5:0]  a;
        logic        d;
        if (blk) return INACT;
        f = (idx < 2) ? s : (idx < 4) ? m : h;
        if (f >= 32'd100) p = 7'b1000000;
        else              p = seg_of((idx % 2 == 1) ? int'(f / 10) : int'(f % 10));
        a = 6'(1 << idx);
        d = ((idx == 2) || (idx == 4)) && (s % 2 == 0);
        return {~a, ~p, ~d};
    endfunction

    // Model: edge n after reset shows digit ((n-1)/div)%6; frame values reload on edge 1 and every 6*div edges
    int          mn[2];
    logic [31:0] msnap[2][3];
    logic [13:0] mexp[2];

    always @(posedge clk or posedge reset) begin
        int div, idx;
        for (int k = 0; k < 2; k++) begin
            div = (k == 0) ? 4 : 1;
            if (reset) begin
                mn[k] = 0;
                for (int j = 0; j < 3; j++) msnap[k][j] = 32'd0;
                mexp[k] = INACT;
            end else begin
                mn[k] = mn[k] + 1;
                idx = ((mn[k] - 1) / div) % 6;
                mexp[k] = model_out(idx, msnap[k][0], msnap[k][1], msnap[k][2], blank);
                if (mn[k] == 1 || mn[k] % (6 * div) == 0) begin
                    msnap[k][0] = sec;
                    msnap[k][1] = min;
                    msnap[k][2] = hrs;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic step();
        @(negedge clk);
        edge_cnt++;
        chk("dut4_outputs", {18'd0, an4, seg4, dp4}, {18'd0, mexp[0]});
        chk("dut1_outputs", {18'd0, an1, seg1, dp1}, {18'd0, mexp[1]});
    endtask

    task automatic run_to(input int n);
        while (edge_cnt < n) step();
    endtask

    initial begin
        repeat (3) step();
        chk("reset_an", {26'd0, an4}, 32'h3F);
        chk("reset_seg", {25'd0, seg4}, 32'h7F);
        chk("reset_dp", {31'd0, dp4}, 32'd1);

        reset = 1'b0;
        edge_cnt = 0;
        step();
        chk("first_edge_seg_zero_snapshot", {25'd0, seg4}, {25'd0, 7'b1000000});
        chk("first_edge_an", {26'd0, an4}, {26'd0, 6'b111110});
        step();
        chk("sec_units_7", {25'd0, seg4}, {25'd0, 7'b1111000});
        chk("div1_an_idx1", {26'd0, an1}, {26'd0, 6'b111101});
        run_to(10);
        chk("min_units_4_an", {26'd0, an4}, {26'd0, 6'b111011});
        chk("min_units_4_seg", {25'd0, seg4}, {25'd0, 7'b0011001});
        chk("dp_sec_odd", {31'd0, dp4}, 32'd1);
        run_to(22);
        chk("hrs_tens_1_an", {26'd0, an4}, {26'd0, 6'b011111});
        chk("hrs_tens_1_seg", {25'd0, seg4}, {25'd0, 7'b1111001});

        run_to(30);
        sec = 32'd8;
        run_to(58);
        chk("dp_even_idx2", {31'd0, dp4}, 32'd0);
        run_to(62);
        chk("dp_even_idx3", {31'd0, dp4}, 32'd1);
        run_to(66);
        chk("dp_even_idx4", {31'd0, dp4}, 32'd0);
        sec = 32'd9;
        run_to(82);
        chk("dp_odd_idx2", {31'd0, dp4}, 32'd1);

        run_to(109);
        min = 32'd35;
        run_to(110);
        chk("min_tens_mid_frame", {25'd0, seg4}, {25'd0, 7'b0110000});
        run_to(130);
        chk("min_units_next_frame", {25'd0, seg4}, {25'd0, 7'b0010010});

        hrs = 32'd150;
        run_to(158);
        chk("min_unaffected_by_hrs_ovf", {25'd0, seg4}, {25'd0, 7'b0110000});
        run_to(162);
        chk("hrs150_units_dash", {25'd0, seg4}, {25'd0, 7'b0111111});
        run_to(166);
        chk("hrs150_tens_dash", {25'd0, seg4}, {25'd0, 7'b0111111});
        hrs = 32'h8000_0005;
        run_to(186);
        chk("hrs_msb_dash", {25'd0, seg4}, {25'd0, 7'b0111111});
        hrs = 32'd12;

        run_to(201);
        blank = 1'b1;
        step();
        chk("blank_an4", {26'd0, an4}, 32'h3F);
        chk("blank_an1", {26'd0, an1}, 32'h3F);
        run_to(211);
        blank = 1'b0;
        step();
        chk("unblank_an_continues", {26'd0, an4}, {26'd0, 6'b101111});
        chk("unblank_seg_hrs_units", {25'd0, seg4}, {25'd0, 7'b0100100});

        run_to(229);
        sec = 32'd21;
        min = 32'd42;
        hrs = 32'd9;
        reset = 1'b1;
        #1;
        chk("async_reset_an", {26'd0, an4}, 32'h3F);
        chk("async_reset_seg", {25'd0, seg4}, 32'h7F);
        chk("async_reset_dp", {31'd0, dp4}, 32'd1);
        step();
        step();
        reset = 1'b0;
        edge_cnt = 0;
        step();
        chk("restart_idx0_an", {26'd0, an4}, {26'd0, 6'b111110});
        chk("restart_seg_zero", {25'd0, seg4}, {25'd0, 7'b1000000});
        step();
        chk("restart_snapshot_sec", {25'd0, seg4}, {25'd0, 7'b1111001});
        chk("div1_restart_idx1", {26'd0, an1}, {26'd0, 6'b111101});
        step();
        chk("div1_restart_idx2", {26'd0, an1}, {26'd0, 6'b111011});
        run_to(20);
        chk("restart_hrs_units_9", {25'd0, seg4}, {25'd0, 7'b0010000});
        run_to(60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
